// File: rtl/cond_flag_unit.sv
// Condition/flag stage: holds NZCV, evaluates the ARM condition field against it,
// gates PCSrc/RegWrite/MemWrite and registers the result as a one-deep pipeline stage.
module cond_flag_unit #(
  parameter int unsigned CNT_W     = 16,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cond,
  input  logic [3:0]       ALU_Flags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             cond_ex,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] skip_count
);

  // Handshake: a transfer happens on any edge where valid && ready. The held result
  // stays stable while out_valid && !out_ready; the stage refills in the same cycle
  // it drains, so out_ready=1 gives one instruction per clock.
  logic accept;
  logic pass;
  logic flag_n, flag_z, flag_c, flag_v;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign {flag_n, flag_z, flag_c, flag_v} = Flags;

  // Evaluated on the stored flags, so an instruction never sees its own update.
  always_comb begin
    pass = 1'b1;
    case (cond)
      4'b0000: pass = flag_z;
      4'b0001: pass = ~flag_z;
      4'b0010: pass = flag_c;
      4'b0011: pass = ~flag_c;
      4'b0100: pass = flag_n;
      4'b0101: pass = ~flag_n;
      4'b0110: pass = flag_v;
      4'b0111: pass = ~flag_v;
      4'b1000: pass = flag_c & ~flag_z;
      4'b1001: pass = ~flag_c | flag_z;
      4'b1010: pass = (flag_n == flag_v);
      4'b1011: pass = (flag_n != flag_v);
      4'b1100: pass = ~flag_z & (flag_n == flag_v);
      4'b1101: pass = flag_z | (flag_n != flag_v);
      default: pass = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Flags      <= FLAGS_RST;
      out_valid  <= 1'b0;
      PCSrc      <= 1'b0;
      RegWrite   <= 1'b0;
      MemWrite   <= 1'b0;
      cond_ex    <= 1'b0;
      exec_count <= '0;
      skip_count <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      cond_ex   <= pass;
      PCSrc     <= PCS & pass;
      RegWrite  <= RegW & ~NoWrite & pass;
      MemWrite  <= MemW & pass;
      if (pass) begin
        if (FlagW[1]) Flags[3:2] <= ALU_Flags[3:2];
        if (FlagW[0]) Flags[1:0] <= ALU_Flags[1:0];
        if (exec_count != '1) exec_count <= exec_count + CNT_W'(1);
      end else begin
        if (skip_count != '1) skip_count <= skip_count + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: condition codes, flag updates, NoWrite,
// backpressure, counter saturation (CNT_W=4) and asynchronous reset.
module tb_cond_flag_unit;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cond;
  logic [3:0]       ALU_Flags;
  logic [1:0]       FlagW;
  logic             PCS, RegW, MemW, NoWrite;
  logic             out_valid;
  logic             out_ready;
  logic             PCSrc, RegWrite, MemWrite, cond_ex;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] exec_count, skip_count;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_ctl;

  cond_flag_unit #(.CNT_W(CNT_W), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .ALU_Flags(ALU_Flags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .out_valid(out_valid), .out_ready(out_ready),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .cond_ex(cond_ex),
    .Flags(Flags), .exec_count(exec_count), .skip_count(skip_count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present one instruction and advance past the next rising edge.
  task automatic send(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                      input logic pcs, input logic regw, input logic memw, input logic nw);
    in_valid  = 1'b1;
    cond      = c;
    ALU_Flags = alu;
    FlagW     = fw;
    PCS       = pcs;
    RegW      = regw;
    MemW      = memw;
    NoWrite   = nw;
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl(input string tag);
    exp_ctl = exp_q.pop_front();
    chk(tag, {29'd0, PCSrc, RegWrite, MemWrite}, {29'd0, exp_ctl});
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cond = 4'd0; ALU_Flags = 4'd0; FlagW = 2'd0;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    @(posedge clk); #1;
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_exec", exec_count, 0);
    chk("rst_skip", skip_count, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // EQ with Z=0 fails
    send(4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0);
    chk("eq_fail_valid", out_valid, 1);
    chk("eq_fail_cond_ex", cond_ex, 0);
    chk("eq_fail_regwrite", RegWrite, 0);
    chk("eq_fail_skip", skip_count, 1);

    // CMP sets Z; NoWrite suppresses RegWrite
    send(4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1);
    chk("cmp_regwrite", RegWrite, 0);
    chk("cmp_cond_ex", cond_ex, 1);
    chk("cmp_flags", Flags, 4'b0100);
    send(4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0);
    chk("eq_pass_regwrite", RegWrite, 1);
    chk("eq_pass_exec", exec_count, 2);

    // Flags = 1000 (N=1, V=0)
    send(4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0);
    chk("set_n_flags", Flags, 4'b1000);
    send(4'b1011, 4'b0000, 2'b00, 0, 0, 1, 0);
    chk("lt_cond_ex", cond_ex, 1);
    chk("lt_memwrite", MemWrite, 1);
    send(4'b1010, 4'b0000, 2'b00, 0, 0, 1, 0);
    chk("ge_cond_ex", cond_ex, 0);
    chk("ge_memwrite", MemWrite, 0);
    send(4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0);
    chk("gt_cond_ex", cond_ex, 0);
    chk("gt_pcsrc", PCSrc, 0);
    send(4'b1101, 4'b0000, 2'b00, 1, 0, 0, 0);
    chk("le_cond_ex", cond_ex, 1);
    chk("le_pcsrc", PCSrc, 1);
    chk("le_exec", exec_count, 5);
    chk("le_skip", skip_count, 3);

    // Partial update, then a failed condition must not touch flags
    send(4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
    chk("set_all_flags", Flags, 4'b1111);
    send(4'b1110, 4'b0000, 2'b10, 0, 0, 0, 0);
    chk("partial_nz_flags", Flags, 4'b0011);
    send(4'b0000, 4'b1100, 2'b11, 1, 1, 1, 0);
    chk("fail_keep_flags", Flags, 4'b0011);
    chk("fail_ctl", {PCSrc, RegWrite, MemWrite}, 3'b000);
    chk("fail_skip", skip_count, 4);

    // Drain with no new input
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_out_valid", out_valid, 0);

    // Backpressure
    out_ready = 1'b0;
    send(4'b1110, 4'b1000, 2'b11, 0, 1, 0, 0);
    chk("bp_accept_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_flags0", Flags, 4'b1000);
    chk("bp_exec0", exec_count, 8);
    cond = 4'b1110; ALU_Flags = 4'b0100; FlagW = 2'b11; RegW = 1'b0; MemW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_flags", Flags, 4'b1000);
      chk("bp_hold_ctl", {PCSrc, RegWrite, MemWrite}, 3'b010);
      chk("bp_hold_exec", exec_count, 8);
    end
    out_ready = 1'b1;
    exp_q.push_back(3'b001);
    @(posedge clk); #1;
    check_ctl("release_ctl0");
    chk("release_flags0", Flags, 4'b0100);
    exp_q.push_back(3'b100);
    send(4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
    check_ctl("release_ctl1");
    chk("release_exec", exec_count, 10);
    chk("release_valid", out_valid, 1);

    // Saturation at 15
    for (int i = 0; i < 20; i++) begin
      send(4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0);
      if (i == 4) chk("sat_reach", exec_count, 15);
    end
    chk("sat_exec", exec_count, 15);
    chk("sat_skip", skip_count, 4);
    chk("sat_regwrite", RegWrite, 1);

    // Asynchronous reset mid-stream
    reset_n = 1'b0;
    #2;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_flags", Flags, 4'b0000);
    chk("arst_ctl", {cond_ex, PCSrc, RegWrite, MemWrite}, 4'b0000);
    chk("arst_exec", exec_count, 0);
    chk("arst_skip", skip_count, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
